// File: rtl/pid_speed_ctrl_pkg.sv
// Shared widths, saturation limits and a signed saturation helper for pid_speed_ctrl.
package pid_pkg;

    localparam int ERR_W  = 10;
    localparam int DIFF_W = 7;
    localparam int INT_W  = 15;
    localparam int SPD_W  = 12;

    localparam int ERR_MAX  = (1 << (ERR_W - 1)) - 1;
    localparam int ERR_MIN  = -(1 << (ERR_W - 1));
    localparam int DIFF_MAX = (1 << (DIFF_W - 1)) - 1;
    localparam int DIFF_MIN = -(1 << (DIFF_W - 1));
    localparam int INT_MAX  = (1 << (INT_W - 1)) - 1;
    localparam int INT_MIN  = -(1 << (INT_W - 1));
    localparam int SPD_MAX  = (1 << SPD_W) - 1;

    // Saturate v to the two's-complement range of an n-bit signed number.
    function automatic int sat_n(input int v, input int n);
        int hi;
        int lo;
        hi = (1 << (n - 1)) - 1;
        lo = -(1 << (n - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/pid_speed_ctrl_if.sv
// Error-in / speed-out bundle between the error datapath, the PID block and the PWM drivers.
interface pid_speed_ctrl_if
    import pid_pkg::*;
;
    logic signed [15:0]      error;
    logic                    err_vld;
    logic                    go;
    logic        [SPD_W-1:0] lft_spd;
    logic        [SPD_W-1:0] rght_spd;
    logic                    spd_vld;

    modport master (
        output error, err_vld, go,
        input  lft_spd, rght_spd, spd_vld
    );

    modport slave (
        input  error, err_vld, go,
        output lft_spd, rght_spd, spd_vld
    );

endinterface

// File: rtl/pid_speed_ctrl_sat.sv
// Combinational signed saturator: narrows an IN_W-bit signed value to OUT_W bits.
module sat_signed
    import pid_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 10
) (
    input  logic signed [IN_W-1:0]  i_din,
    output logic signed [OUT_W-1:0] o_dout
);

    logic signed [31:0] w_wide;
    logic signed [31:0] w_sat;

    assign w_wide = 32'(i_din);
    assign w_sat  = sat_n(w_wide, OUT_W);
    assign o_dout = OUT_W'(w_sat);

endmodule

// File: rtl/pid_speed_ctrl.sv
// 3-stage pipelined PID turning line error into left/right motor speeds.
// Optional build macro ANTI_WINDUP_EN freezes the integrator while the last output was clamped.
module pid_speed_ctrl
    import pid_pkg::*;
#(
    parameter int P_COEFF  = 12,
    parameter int D_COEFF  = 7,
    parameter int I_SHIFT  = 4,
    parameter int BASE_SPD = 768
) (
    input  logic            clk,
    input  logic            rst_n,
    pid_speed_ctrl_if.slave bus
);

    localparam logic signed [15:0]    P_K       = 16'(P_COEFF);
    localparam logic signed [ERR_W:0] D_K       = (ERR_W + 1)'(D_COEFF);
    localparam logic signed [17:0]    BASE_K    = 18'(BASE_SPD);
    localparam logic signed [17:0]    SPD_MAX_S = 18'(SPD_MAX);

    logic signed [ERR_W-1:0]  w_err_sat;
    logic signed [ERR_W:0]    w_diff_raw;
    logic signed [DIFF_W-1:0] w_diff_sat;
    logic signed [INT_W:0]    w_int_sum;
    logic signed [INT_W-1:0]  w_int_sat;
    logic signed [INT_W-1:0]  w_int_next;
    logic signed [15:0]       w_pid;
    logic signed [17:0]       w_sum [2];
    logic [1:0][SPD_W-1:0]    w_spd;
    logic                     w_clear;

    logic signed [ERR_W-1:0]  r_s1_err;
    logic signed [DIFF_W-1:0] r_s1_diff;
    logic signed [ERR_W-1:0]  r_prev_err;
    logic signed [INT_W-1:0]  r_integ;
    logic                     r_s1_vld;
    logic signed [15:0]       r_p;
    logic signed [INT_W-1:0]  r_i;
    logic signed [ERR_W:0]    r_d;
    logic                     r_s2_vld;
    logic        [SPD_W-1:0]  r_lft;
    logic        [SPD_W-1:0]  r_rght;
    logic                     r_spd_vld;

    sat_signed #(.IN_W(16), .OUT_W(ERR_W)) u_sat_err (
        .i_din  (bus.error),
        .o_dout (w_err_sat)
    );

    assign w_diff_raw = (ERR_W + 1)'(w_err_sat) - (ERR_W + 1)'(r_prev_err);

    sat_signed #(.IN_W(ERR_W + 1), .OUT_W(DIFF_W)) u_sat_diff (
        .i_din  (w_diff_raw),
        .o_dout (w_diff_sat)
    );

    assign w_int_sum = (INT_W + 1)'(r_integ) + (INT_W + 1)'(w_err_sat);

    sat_signed #(.IN_W(INT_W + 1), .OUT_W(INT_W)) u_sat_int (
        .i_din  (w_int_sum),
        .o_dout (w_int_sat)
    );

`ifdef ANTI_WINDUP_EN
    logic       r_sat_flag;
    logic [1:0] w_clip;
    assign w_int_next = r_sat_flag ? r_integ : w_int_sat;
`else
    assign w_int_next = w_int_sat;
`endif

    // Index 0 is the left motor (base + pid), index 1 the right motor (base - pid).
    assign w_pid    = r_p + 16'(r_i) + 16'(r_d);
    assign w_sum[0] = BASE_K + 18'(w_pid);
    assign w_sum[1] = BASE_K - 18'(w_pid);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_clamp
            assign w_spd[gi] = (w_sum[gi] < 18'sd0)     ? '0 :
                               (w_sum[gi] > SPD_MAX_S)  ? SPD_W'(SPD_MAX) :
                                                          w_sum[gi][SPD_W-1:0];
`ifdef ANTI_WINDUP_EN
            assign w_clip[gi] = (w_sum[gi] < 18'sd0) || (w_sum[gi] > SPD_MAX_S);
`endif
        end
    endgenerate

    assign w_clear = !rst_n || !bus.go;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_s1_err   <= '0;
            r_s1_diff  <= '0;
            r_prev_err <= '0;
            r_integ    <= '0;
            r_s1_vld   <= 1'b0;
            r_p        <= '0;
            r_i        <= '0;
            r_d        <= '0;
            r_s2_vld   <= 1'b0;
            r_lft      <= '0;
            r_rght     <= '0;
            r_spd_vld  <= 1'b0;
`ifdef ANTI_WINDUP_EN
            r_sat_flag <= 1'b0;
`endif
        end else begin
            r_s1_vld <= bus.err_vld;
            if (bus.err_vld) begin
                r_s1_err   <= w_err_sat;
                r_s1_diff  <= w_diff_sat;
                r_prev_err <= w_err_sat;
                r_integ    <= w_int_next;
            end
            // Stage 2 reads r_integ after the stage-1 update of the same sample.
            r_s2_vld  <= r_s1_vld;
            r_p       <= 16'(r_s1_err) * P_K;
            r_i       <= r_integ >>> I_SHIFT;
            r_d       <= (ERR_W + 1)'(r_s1_diff) * D_K;
            r_spd_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_lft  <= w_spd[0];
                r_rght <= w_spd[1];
`ifdef ANTI_WINDUP_EN
                r_sat_flag <= |w_clip;
`endif
            end
        end
    end

    assign bus.lft_spd  = r_lft;
    assign bus.rght_spd = r_rght;
    assign bus.spd_vld  = r_spd_vld;

endmodule

// File: tb/tb_pid_speed_ctrl.sv
// Self-checking bench for pid_speed_ctrl: hand-computed vector table, corner sequences, random traffic vs model.
module tb_pid_speed_ctrl;

    localparam int P_COEFF  = 12;
    localparam int D_COEFF  = 7;
    localparam int I_SHIFT  = 4;
    localparam int BASE_SPD = 768;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pid_speed_ctrl_if bus ();

    pid_speed_ctrl #(
        .P_COEFF  (P_COEFF),
        .D_COEFF  (D_COEFF),
        .I_SHIFT  (I_SHIFT),
        .BASE_SPD (BASE_SPD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int lft;
        int rght;
    } exp_t;

    typedef struct {
        logic signed [15:0] err;
        int                 lft;
        int                 rght;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t q[$];
    int   m_integ = 0;
    int   m_prev = 0;
    int   held_l = 0;
    int   held_r = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got %0d want %0d", name, cyc, act, req);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Floor division by 2**sh (rounds toward minus infinity).
    function automatic int floor_div(input int v, input int sh);
        int d;
        d = 1 << sh;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    task automatic model_accept(input int e, output int l, output int r);
        int err;
        int diff;
        int pid;
        err     = clampi(e, -512, 511);
        diff    = clampi(err - m_prev, -64, 63);
        m_prev  = err;
        m_integ = clampi(m_integ + err, -16384, 16383);
        pid     = err * P_COEFF + floor_div(m_integ, I_SHIFT) + diff * D_COEFF;
        l       = clampi(BASE_SPD + pid, 0, 4095);
        r       = clampi(BASE_SPD - pid, 0, 4095);
    endtask

    task automatic model_clear();
        q.delete();
        m_integ = 0;
        m_prev  = 0;
        held_l  = 0;
        held_r  = 0;
    endtask

    // Drive one cycle of inputs, advance one edge, then check all outputs against the model.
    task automatic tick(input logic v, input logic g, input logic signed [15:0] e);
        exp_t x;
        bus.err_vld = v;
        bus.go      = g;
        bus.error   = e;
        if (!g) begin
            model_clear();
        end else if (v) begin
            model_accept(int'(e), x.lft, x.rght);
            x.due = cyc + 3;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0 && q[0].due == cyc) begin
            x = q.pop_front();
            held_l = x.lft;
            held_r = x.rght;
            chk("spd_vld", int'(bus.spd_vld), 1);
            $display("cyc %0d spd_vld=%0d lft_spd=%0d rght_spd=%0d", cyc, bus.spd_vld, bus.lft_spd, bus.rght_spd);
        end else begin
            chk("spd_vld_idle", int'(bus.spd_vld), 0);
        end
        chk("lft_spd", int'(bus.lft_spd), held_l);
        chk("rght_spd", int'(bus.rght_spd), held_r);
    endtask

    initial begin
        vec_t vecs[6];
        int   tmp;
        logic v;
        logic g;
        logic signed [15:0] e;

        vecs[0] = '{16'sd20,     1149, 387};
        vecs[1] = '{16'sd20,     1010, 526};
        vecs[2] = '{16'sh7FFF,   4095, 0};
        vecs[3] = '{16'sh8000,   0,    4095};
        vecs[4] = '{16'sd0,      1211, 325};
        vecs[5] = '{-16'sd8,     617,  919};

        // Reset held for two edges while go=1 and err_vld toggles.
        bus.go      = 1'b1;
        bus.error   = 16'sd300;
        bus.err_vld = 1'b1;
        rst_n       = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_spd_vld", int'(bus.spd_vld), 0);
            chk("rst_lft", int'(bus.lft_spd), 0);
            chk("rst_rght", int'(bus.rght_spd), 0);
            bus.err_vld = ~bus.err_vld;
        end
        rst_n = 1'b1;
        model_clear();

        // Hand-computed vectors, one sample in flight at a time.
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1, vecs[i].err);
            tick(1'b0, 1'b1, 16'sd0);
            tick(1'b0, 1'b1, 16'sd0);
            chk("vec_vld", int'(bus.spd_vld), 1);
            chk("vec_lft", int'(bus.lft_spd), vecs[i].lft);
            chk("vec_rght", int'(bus.rght_spd), vecs[i].rght);
        end
        tick(1'b0, 1'b0, 16'sd0);

        // Back-to-back samples 0, 8, -8.
        tick(1'b1, 1'b1, 16'sd0);
        tick(1'b1, 1'b1, 16'sd8);
        tick(1'b1, 1'b1, -16'sd8);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 16'sd0);

        // go drops one cycle after a sample; then a fresh sample must see cleared state.
        tick(1'b1, 1'b1, 16'sd50);
        tick(1'b0, 1'b0, 16'sd0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 16'sd0);
        tick(1'b1, 1'b1, 16'sd20);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 16'sd0);
        chk("go_restart_lft", int'(bus.lft_spd), 1149);

        // go low in the same cycle as err_vld drops the sample.
        tick(1'b1, 1'b0, 16'sd99);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 16'sd0);

        // Integrator driven into its upper limit.
        for (int i = 0; i < 40; i++) tick(1'b1, 1'b1, 16'sd511);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 16'sd0);
        chk("integ_pinned", m_integ, 16383);
        tick(1'b0, 1'b0, 16'sd0);

        // Reset in the middle of the pipeline discards the in-flight sample.
        tick(1'b1, 1'b1, 16'sd100);
        tick(1'b0, 1'b1, 16'sd0);
        bus.err_vld = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        chk("midrst_vld", int'(bus.spd_vld), 0);
        chk("midrst_lft", int'(bus.lft_spd), 0);
        chk("midrst_rght", int'(bus.rght_spd), 0);
        model_clear();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 16'sd0);

        // Random traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            v = ($urandom_range(0, 99) < 60);
            g = ($urandom_range(0, 99) >= 3);
            if ($urandom_range(0, 3) == 0) begin
                e = 16'($urandom);
            end else begin
                tmp = int'($urandom_range(0, 1400)) - 700;
                e = 16'(tmp);
            end
            tick(v, g, e);
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 16'sd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
